ifu_mo_fetch: RTL and testbench

Parametrised next-generation instruction fetch unit. It issues pipelined 32-bit word fetches on the RIB master bus, with up to MAX_OUTST requests in flight. Returned words are buffered, together with their addresses, in a fetch queue of depth FQ_DEPTH. On a BPU or EXU redirect it flushes the queue and silently drops responses that are still in flight. It sits between the PC/branch logic and the decode (16/32-bit merge) stage.

---
 rtl/ifu_mo_fetch_if.sv | 44 ++++
 rtl/ifu_mo_fetch.sv | 164 ++++++++++++++++
 tb/tb_ifu_mo_fetch.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_mo_fetch_if.sv
// -----------------------------------------------------------------------------
// ifu_mo_fetch_if
// Bundles every non-clock/reset signal of the instruction fetch unit:
//   - PC-side control : i_fetch_vld, i_bpu_taken/i_bpu_jaddr, i_exu_taken/i_exu_jaddr
//   - decode delivery : o_data_vld, o_iaddr, o_data
//   - RIB master bus  : o_ribm_addr/wrcs/mask/wdata/req/rdy, i_ribm_rdata/gnt/rsp
// Modport 'master' is taken by the fetch unit (it is the RIB bus master);
// modport 'slave' is the view of the surrounding logic / bus / testbench.
// -----------------------------------------------------------------------------
interface ifu_mo_fetch_if #(
   parameter int XLEN = 32
);
   logic            i_fetch_vld;
   logic            i_bpu_taken;
   logic [XLEN-1:0] i_bpu_jaddr;
   logic            i_exu_taken;
   logic [XLEN-1:0] i_exu_jaddr;
   logic            o_data_vld;
   logic [XLEN-1:0] o_iaddr;
   logic [31:0]     o_data;
   logic [31:0]     o_ribm_addr;
   logic            o_ribm_wrcs;
   logic [3:0]      o_ribm_mask;
   logic [31:0]     o_ribm_wdata;
   logic [31:0]     i_ribm_rdata;
   logic            o_ribm_req;
   logic            i_ribm_gnt;
   logic            i_ribm_rsp;
   logic            o_ribm_rdy;

   modport master (
      input  i_fetch_vld, i_bpu_taken, i_bpu_jaddr, i_exu_taken, i_exu_jaddr,
      input  i_ribm_rdata, i_ribm_gnt, i_ribm_rsp,
      output o_data_vld, o_iaddr, o_data,
      output o_ribm_addr, o_ribm_wrcs, o_ribm_mask, o_ribm_wdata, o_ribm_req, o_ribm_rdy
   );

   modport slave (
      output i_fetch_vld, i_bpu_taken, i_bpu_jaddr, i_exu_taken, i_exu_jaddr,
      output i_ribm_rdata, i_ribm_gnt, i_ribm_rsp,
      input  o_data_vld, o_iaddr, o_data,
      input  o_ribm_addr, o_ribm_wrcs, o_ribm_mask, o_ribm_wdata, o_ribm_req, o_ribm_rdy
   );
endinterface

// File: rtl/ifu_mo_fetch.sv
// -----------------------------------------------------------------------------
// ifu_mo_fetch
// Pipelined instruction fetch unit. Issues 32-bit word reads on the RIB bus
// with up to MAX_OUTST requests in flight, buffers returned words with their
// addresses in a FQ_DEPTH-entry fetch queue and hands them to decode.
// A BPU/EXU redirect flushes the queue and marks all in-flight responses
// for silent discard.
// Ports:
//   i_clk  : clock
//   i_rst  : synchronous active-high reset
//   bus    : ifu_mo_fetch_if.master (PC control, decode delivery, RIB master)
// -----------------------------------------------------------------------------
module ifu_mo_fetch #(
   parameter int              XLEN      = 32,
   parameter int              MAX_OUTST = 4,
   parameter int              FQ_DEPTH  = 4,
   parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h8000_0000)
) (
   input  logic           i_clk,
   input  logic           i_rst,
   ifu_mo_fetch_if.master bus
);

   localparam int OCW = $clog2(MAX_OUTST + 1);
   localparam int FCW = $clog2(FQ_DEPTH + 1);
   localparam int APW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int FPW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
   localparam logic [OCW-1:0] OUTST_MAX = OCW'(MAX_OUTST);
   localparam logic [APW-1:0] AF_LAST   = APW'(MAX_OUTST - 1);
   localparam logic [FPW-1:0] FQ_LAST   = FPW'(FQ_DEPTH - 1);

   // State
   logic [XLEN-1:0] pc_q, pc_d;
   logic [OCW-1:0]  outst_cnt_q, outst_cnt_d;
   logic [OCW-1:0]  drop_cnt_q, drop_cnt_d;
   logic [FCW-1:0]  fq_cnt_q, fq_cnt_d;
   logic [APW-1:0]  af_wr_q, af_wr_d, af_rd_q, af_rd_d;
   logic [FPW-1:0]  fq_wr_q, fq_wr_d, fq_rd_q, fq_rd_d;

   // Storage: in-flight address FIFO and fetch queue (no reset, RAM-friendly)
   logic [XLEN-1:0] af_mem      [MAX_OUTST];
   logic [XLEN-1:0] fq_addr_mem [FQ_DEPTH];
   logic [31:0]     fq_data_mem [FQ_DEPTH];

   // Control
   logic            redir;
   logic [XLEN-1:0] target_raw, target;
   logic            rsp_acc;
   logic [31:0]     live_cnt;
   logic            req;
   logic            grant;
   logic            fq_empty;
   logic            data_vld;
   logic            fq_push;

   function automatic logic [APW-1:0] af_inc(input logic [APW-1:0] p);
      return (p == AF_LAST) ? '0 : p + APW'(1);
   endfunction

   function automatic logic [FPW-1:0] fq_inc(input logic [FPW-1:0] p);
      return (p == FQ_LAST) ? '0 : p + FPW'(1);
   endfunction

   always_comb begin
      redir      = bus.i_exu_taken | bus.i_bpu_taken;
      target_raw = bus.i_exu_taken ? bus.i_exu_jaddr : bus.i_bpu_jaddr;
      target     = target_raw & ~XLEN'(3);

      // A response with nothing outstanding is a leftover from before a
      // reset and is ignored.
      rsp_acc    = bus.i_ribm_rsp & ~i_rst & (outst_cnt_q != '0);

      // Live = responses that will land in the queue + entries already there.
      // Keeping it below FQ_DEPTH reserves a queue slot for every live reply,
      // so the queue can never overflow and the bus never has to be stalled.
      live_cnt   = 32'(outst_cnt_q) - 32'(drop_cnt_q) + 32'(fq_cnt_q);
      req        = ~i_rst & bus.i_fetch_vld & ~redir &
                   (outst_cnt_q < OUTST_MAX) & (live_cnt < 32'(FQ_DEPTH));
      grant      = req & bus.i_ribm_gnt;

      fq_empty   = (fq_cnt_q == '0);
      data_vld   = ~i_rst & bus.i_fetch_vld & ~fq_empty & ~redir;
      // A response arriving in a redirect cycle is discarded with the flush.
      fq_push    = rsp_acc & (drop_cnt_q == '0) & ~redir;
   end

   always_comb begin
      pc_d        = pc_q;
      outst_cnt_d = outst_cnt_q + OCW'(grant) - OCW'(rsp_acc);
      drop_cnt_d  = drop_cnt_q;
      fq_cnt_d    = fq_cnt_q + FCW'(fq_push) - FCW'(data_vld);
      af_wr_d     = grant   ? af_inc(af_wr_q) : af_wr_q;
      af_rd_d     = rsp_acc ? af_inc(af_rd_q) : af_rd_q;
      fq_wr_d     = fq_push  ? fq_inc(fq_wr_q) : fq_wr_q;
      fq_rd_d     = data_vld ? fq_inc(fq_rd_q) : fq_rd_q;

      if (rsp_acc && drop_cnt_q != '0) begin
         drop_cnt_d = drop_cnt_q - OCW'(1);
      end

      if (redir) begin
         pc_d       = target;
         // Everything still in flight after this cycle belongs to the old path.
         drop_cnt_d = outst_cnt_q - OCW'(rsp_acc);
         fq_cnt_d   = '0;
         fq_wr_d    = '0;
         fq_rd_d    = '0;
      end else if (grant) begin
         pc_d = pc_q + XLEN'(4);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pc_q        <= RESET_PC;
         outst_cnt_q <= '0;
         drop_cnt_q  <= '0;
         fq_cnt_q    <= '0;
         af_wr_q     <= '0;
         af_rd_q     <= '0;
         fq_wr_q     <= '0;
         fq_rd_q     <= '0;
      end else begin
         pc_q        <= pc_d;
         outst_cnt_q <= outst_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         fq_cnt_q    <= fq_cnt_d;
         af_wr_q     <= af_wr_d;
         af_rd_q     <= af_rd_d;
         fq_wr_q     <= fq_wr_d;
         fq_rd_q     <= fq_rd_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (grant) begin
         af_mem[af_wr_q] <= pc_q;
      end
      if (fq_push) begin
         fq_addr_mem[fq_wr_q] <= af_mem[af_rd_q];
         fq_data_mem[fq_wr_q] <= bus.i_ribm_rdata;
      end
   end

   assign bus.o_ribm_req   = req;
   assign bus.o_ribm_addr  = 32'(pc_q & ~XLEN'(3));
   assign bus.o_ribm_wrcs  = 1'b0;
   assign bus.o_ribm_mask  = 4'b0000;
   assign bus.o_ribm_wdata = 32'h0;
   assign bus.o_ribm_rdy   = ~i_rst;
   assign bus.o_data_vld   = data_vld;
   assign bus.o_iaddr      = fq_empty ? '0 : fq_addr_mem[fq_rd_q];
   assign bus.o_data       = fq_empty ? '0 : fq_data_mem[fq_rd_q];

   a_outst_max: assert property (@(posedge i_clk) disable iff (i_rst)
      outst_cnt_q <= OUTST_MAX);
   a_drop_le_outst: assert property (@(posedge i_clk) disable iff (i_rst)
      drop_cnt_q <= outst_cnt_q);
   a_fq_max: assert property (@(posedge i_clk) disable iff (i_rst)
      fq_cnt_q <= FCW'(FQ_DEPTH));
   a_rsp_needs_outst: assert property (@(posedge i_clk) disable iff (i_rst)
      rsp_acc |-> (outst_cnt_q != '0));

endmodule

// File: tb/tb_ifu_mo_fetch.sv
module tb_ifu_mo_fetch;

   localparam int          MAX_OUTST = 4;
   localparam int          FQ_DEPTH  = 4;
   localparam logic [31:0] RESET_PC  = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ifu_mo_fetch_if #(.XLEN(32)) bus ();

   ifu_mo_fetch #(
      .XLEN(32), .MAX_OUTST(MAX_OUTST), .FQ_DEPTH(FQ_DEPTH), .RESET_PC(RESET_PC)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model (queues) ----------------
   typedef struct { logic [31:0] addr; bit live; } infl_t;
   typedef struct { logic [31:0] addr; logic [31:0] data; } fqe_t;
   infl_t       infl_q[$];
   fqe_t        fq_q[$];
   logic [31:0] m_pc;

   // last observed outputs, for directed checks
   logic        obs_req, obs_vld;
   logic [31:0] obs_addr, obs_iaddr, obs_data;

   task automatic step(input bit r, input bit fv, input bit gnt, input bit rsp,
                       input logic [31:0] rdata, input bit bpu, input logic [31:0] baddr,
                       input bit exu, input logic [31:0] eaddr);
      bit          redir, e_req, e_vld, have;
      int          live;
      logic [31:0] e_iaddr, e_data;
      infl_t       e;
      fqe_t        nw;
      rst = r;
      bus.i_fetch_vld = fv;  bus.i_ribm_gnt = gnt;  bus.i_ribm_rsp = rsp;
      bus.i_ribm_rdata = rdata;
      bus.i_bpu_taken = bpu; bus.i_bpu_jaddr = baddr;
      bus.i_exu_taken = exu; bus.i_exu_jaddr = eaddr;
      redir = bpu | exu;
      live = 0;
      foreach (infl_q[i]) if (infl_q[i].live) live++;
      e_req = !r && fv && !redir && (infl_q.size() < MAX_OUTST) && (live + fq_q.size() < FQ_DEPTH);
      e_vld = !r && fv && !redir && (fq_q.size() > 0);
      e_iaddr = (fq_q.size() > 0) ? fq_q[0].addr : 32'h0;
      e_data  = (fq_q.size() > 0) ? fq_q[0].data : 32'h0;
      @(negedge clk);
      obs_req = bus.o_ribm_req;  obs_addr = bus.o_ribm_addr;  obs_vld = bus.o_data_vld;
      obs_iaddr = bus.o_iaddr;   obs_data = bus.o_data;
      check("req", {31'b0, bus.o_ribm_req}, {31'b0, e_req});
      if (e_req) check("ribm_addr", bus.o_ribm_addr, m_pc);
      check("data_vld", {31'b0, bus.o_data_vld}, {31'b0, e_vld});
      check("iaddr", bus.o_iaddr, e_iaddr);
      check("data", bus.o_data, e_data);
      check("rdy", {31'b0, bus.o_ribm_rdy}, {31'b0, !r});
      @(posedge clk);
      if (r) begin
         infl_q.delete(); fq_q.delete(); m_pc = RESET_PC;
      end else begin
         have = 0;
         if (rsp && infl_q.size() > 0) begin
            e = infl_q.pop_front();
            if (e.live && !redir) begin
               have = 1; nw.addr = e.addr; nw.data = rdata;
            end
         end
         if (e_vld) void'(fq_q.pop_front());
         if (have) fq_q.push_back(nw);
         if (redir) begin
            fq_q.delete();
            foreach (infl_q[i]) infl_q[i].live = 0;
            m_pc = (exu ? eaddr : baddr) & ~32'h3;
         end else if (e_req && gnt) begin
            e.addr = m_pc; e.live = 1;
            infl_q.push_back(e);
            m_pc = m_pc + 32'd4;
         end
      end
      #1;
   endtask

   // Respond to everything in flight; the first delivered word must be exp_addr.
   task automatic drain_first(input string name, input logic [31:0] exp_addr);
      bit          found;
      logic [31:0] first;
      found = 0; first = 32'h0;
      for (int k = 0; k < 16; k++) begin
         step(0, 1, 0, infl_q.size() > 0, $urandom, 0, 0, 0, 0);
         if (obs_vld && !found) begin found = 1; first = obs_iaddr; end
      end
      check({name, "_found"}, {31'b0, found}, 32'd1);
      check(name, first, exp_addr);
   endtask

   // ---------------- table vectors ----------------
   typedef struct {
      bit r, fv, gnt, rsp;
      logic [31:0] rdata;
      bit e_req;
      logic [31:0] e_addr;
      bit e_vld;
      logic [31:0] e_iaddr, e_data;
   } vec_t;

   function automatic vec_t mk(bit r, bit fv, bit gnt, bit rsp, logic [31:0] rdata,
                               bit e_req, logic [31:0] e_addr, bit e_vld,
                               logic [31:0] e_iaddr, logic [31:0] e_data);
      vec_t v;
      v.r = r; v.fv = fv; v.gnt = gnt; v.rsp = rsp; v.rdata = rdata;
      v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
      v.e_iaddr = e_iaddr; v.e_data = e_data;
      return v;
   endfunction

   vec_t vecs[8];
   int   ngr;
   logic [31:0] gaddr[8];

   initial begin
      vecs[0] = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0);
      vecs[1] = mk(0, 1, 1, 0, 32'h0,         1, 32'h8000_0000, 0, 32'h0,         32'h0);
      vecs[2] = mk(0, 1, 1, 1, 32'hA000_0000, 1, 32'h8000_0004, 0, 32'h0,         32'h0);
      vecs[3] = mk(0, 1, 1, 1, 32'hA000_0001, 1, 32'h8000_0008, 1, 32'h8000_0000, 32'hA000_0000);
      vecs[4] = mk(0, 1, 1, 1, 32'hA000_0002, 1, 32'h8000_000C, 1, 32'h8000_0004, 32'hA000_0001);
      vecs[5] = mk(0, 1, 0, 1, 32'hA000_0003, 1, 32'h8000_0010, 1, 32'h8000_0008, 32'hA000_0002);
      vecs[6] = mk(0, 1, 0, 0, 32'h0,         1, 32'h8000_0010, 1, 32'h8000_000C, 32'hA000_0003);
      vecs[7] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0);

      rst = 1'b1;
      bus.i_fetch_vld = 0; bus.i_bpu_taken = 0; bus.i_bpu_jaddr = 0;
      bus.i_exu_taken = 0; bus.i_exu_jaddr = 0; bus.i_ribm_rdata = 0;
      bus.i_ribm_gnt = 0; bus.i_ribm_rsp = 0;

      // Streaming fetch, grant every cycle, response one cycle later
      for (int i = 0; i < 8; i++) begin
         rst = vecs[i].r;
         bus.i_fetch_vld = vecs[i].fv; bus.i_ribm_gnt = vecs[i].gnt;
         bus.i_ribm_rsp = vecs[i].rsp; bus.i_ribm_rdata = vecs[i].rdata;
         @(negedge clk);
         $display("vec %0d: req=%b addr=%h vld=%b iaddr=%h data=%h", i,
                  bus.o_ribm_req, bus.o_ribm_addr, bus.o_data_vld, bus.o_iaddr, bus.o_data);
         check($sformatf("vec%0d_req", i), {31'b0, bus.o_ribm_req}, {31'b0, vecs[i].e_req});
         if (vecs[i].e_req) check($sformatf("vec%0d_addr", i), bus.o_ribm_addr, vecs[i].e_addr);
         check($sformatf("vec%0d_vld", i), {31'b0, bus.o_data_vld}, {31'b0, vecs[i].e_vld});
         check($sformatf("vec%0d_iaddr", i), bus.o_iaddr, vecs[i].e_iaddr);
         check($sformatf("vec%0d_data", i), bus.o_data, vecs[i].e_data);
         check($sformatf("vec%0d_rdy", i), {31'b0, bus.o_ribm_rdy}, {31'b0, !vecs[i].r});
         check($sformatf("vec%0d_const", i), {bus.o_ribm_wrcs, bus.o_ribm_mask, bus.o_ribm_wdata[26:0]}, 32'h0);
         @(posedge clk); #1;
      end

      // Responses withheld: exactly MAX_OUTST grants
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      ngr = 0;
      for (int k = 0; k < 6; k++) begin
         step(0, 1, 1, 0, 0, 0, 0, 0, 0);
         if (obs_req) begin gaddr[ngr] = obs_addr; ngr++; end
      end
      $display("outst limit: grants=%0d last_req=%b", ngr, obs_req);
      check("outst_grants", ngr, MAX_OUTST);
      for (int k = 0; k < 4; k++) check($sformatf("outst_addr%0d", k), gaddr[k], RESET_PC + 32'(4 * k));
      check("outst_req_low", {31'b0, obs_req}, 32'd0);

      // EXU redirect with 4 in flight
      step(0, 1, 1, 0, 0, 0, 0, 1, 32'h0000_1002);
      check("exu_redir_req", {31'b0, obs_req}, 32'd0);
      step(0, 1, 0, 1, $urandom, 0, 0, 0, 0);
      step(0, 1, 1, 1, $urandom, 0, 0, 0, 0);
      $display("exu redirect: req=%b addr=%h", obs_req, obs_addr);
      check("exu_next_req", {31'b0, obs_req}, 32'd1);
      check("exu_next_addr", obs_addr, 32'h0000_1000);
      drain_first("exu_first_iaddr", 32'h0000_1000);

      // BPU + EXU together with a response
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 1, 32'hDEAD_0000, 1, 32'h0000_2000, 1, 32'h0000_3000);
      check("both_redir_vld", {31'b0, obs_vld}, 32'd0);
      step(0, 1, 1, 0, 0, 0, 0, 0, 0);
      $display("bpu+exu redirect: req=%b addr=%h", obs_req, obs_addr);
      check("both_next_addr", obs_addr, 32'h0000_3000);
      drain_first("both_first_iaddr", 32'h0000_3000);

      // Stall with 4 in flight: queue fills, then drains in 4 cycles
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) step(0, 1, 1, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 1, 1, 32'hB000_0000 + 32'(k), 0, 0, 0, 0);
         check($sformatf("stall_req%0d", k), {31'b0, obs_req}, 32'd0);
      end
      for (int k = 0; k < 4; k++) begin
         step(0, 1, 0, 0, 0, 0, 0, 0, 0);
         $display("drain %0d: vld=%b iaddr=%h data=%h", k, obs_vld, obs_iaddr, obs_data);
         check($sformatf("drain_vld%0d", k), {31'b0, obs_vld}, 32'd1);
         check($sformatf("drain_iaddr%0d", k), obs_iaddr, RESET_PC + 32'(4 * k));
         check($sformatf("drain_data%0d", k), obs_data, 32'hB000_0000 + 32'(k));
      end
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      check("drain_empty", {31'b0, obs_vld}, 32'd0);

      // PC wrap, then reset mid-burst
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE);
      step(0, 1, 1, 0, 0, 0, 0, 0, 0);
      check("wrap_addr0", obs_addr, 32'hFFFF_FFFC);
      step(0, 1, 1, 0, 0, 0, 0, 0, 0);
      $display("wrap: addr=%h", obs_addr);
      check("wrap_addr1", obs_addr, 32'h0000_0000);
      step(0, 1, 1, 1, 32'h1111_1111, 0, 0, 0, 0);
      step(1, 1, 1, 1, 32'h2222_2222, 0, 0, 0, 0);
      check("rst_mid_req", {31'b0, obs_req}, 32'd0);
      check("rst_mid_vld", {31'b0, obs_vld}, 32'd0);
      step(0, 1, 1, 1, 32'h3333_3333, 0, 0, 0, 0);
      $display("after reset: req=%b addr=%h vld=%b", obs_req, obs_addr, obs_vld);
      check("rst_after_vld", {31'b0, obs_vld}, 32'd0);
      check("rst_refetch", obs_addr, RESET_PC);
      drain_first("rst_first_iaddr", RESET_PC);

      // Randomized traffic against the model
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 3000; c++) begin
         bit r, fv, gnt, rsp, bpu, exu;
         r   = ($urandom_range(0, 199) == 0);
         fv  = ($urandom_range(0, 9) < 8);
         gnt = ($urandom_range(0, 9) < 7);
         rsp = (infl_q.size() > 0) && ($urandom_range(0, 1) == 1);
         bpu = ($urandom_range(0, 29) == 0);
         exu = ($urandom_range(0, 29) == 0);
         step(r, fv, gnt, rsp, $urandom, bpu, $urandom, exu, $urandom);
      end
      $display("random phase done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
